step_responder: RTL and testbench

Execution-side counterpart of the accelerator's state controller. Consumes the 3-bit state bus, produces one-cycle per-state strobes with iteration-indexed addresses, counts traversal iterations, and drives `finish` back to the controller. Sits between the controller and the param/data/write-back memory ports, and is the single source of the controller's `finish` input.

---
 rtl/acc_pkg.sv | 21 ++
 rtl/state_entry_decode.sv | 43 ++++
 rtl/step_responder.sv | 114 +++++++++++
 tb/tb_step_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared accelerator definitions: controller state codes and default memory map.
package acc_pkg;

    localparam int STATE_W    = 3;
    localparam int NUM_STATES = 7;

    // Controller state codes; code 7 is never issued by a healthy controller.
    localparam logic [STATE_W-1:0] IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] GET_PARAM  = 3'd1;
    localparam logic [STATE_W-1:0] GET_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] EX         = 3'd3;
    localparam logic [STATE_W-1:0] WRIT_PRE   = 3'd4;
    localparam logic [STATE_W-1:0] WRITE_BACK = 3'd5;
    localparam logic [STATE_W-1:0] DONE       = 3'd6;

    // Default base addresses of the parameter, input and result tables.
    localparam logic [15:0] PARAM_BASE_DEF = 16'h0000;
    localparam logic [15:0] DATA_BASE_DEF  = 16'h1000;
    localparam logic [15:0] WB_BASE_DEF    = 16'h2000;

endpackage

// File: rtl/state_entry_decode.sv
// Remembers the previous controller state and flags the cycle in which each
// state is first presented, as a one-hot vector indexed by state code.
module state_entry_decode
    import acc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [STATE_W-1:0]    state,
    output logic [STATE_W-1:0]    state_q,
    output logic [NUM_STATES-1:0] enter_oh
);

    logic [STATE_W-1:0] state_d;
    logic               enter_s;

    // Next previous-state is simply the state seen this cycle.
    always_comb begin
        state_d = state;
    end

    // Previous-state register; reset lands in IDLE so the first GET_PARAM is an entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One-hot entry pulses; the illegal code 7 has no slot and so never pulses.
    always_comb begin
        enter_oh = {NUM_STATES{1'b0}};
        enter_s  = (state != state_q);
        for (int i = 0; i < NUM_STATES; i++) begin
            if (enter_s && (state == STATE_W'(i))) begin
                enter_oh[i] = 1'b1;
            end else begin
                enter_oh[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/step_responder.sv
// Execution-side responder: per-state memory strobes with iteration-indexed
// addresses, iteration counting and the finish handshake back to the controller.
module step_responder
    import acc_pkg::*;
#(
    parameter int                 ADDR_W     = 16,
    parameter int                 CNT_W      = 16,
    parameter logic [ADDR_W-1:0]  PARAM_BASE = ADDR_W'(PARAM_BASE_DEF),
    parameter logic [ADDR_W-1:0]  DATA_BASE  = ADDR_W'(DATA_BASE_DEF),
    parameter logic [ADDR_W-1:0]  WB_BASE    = ADDR_W'(WB_BASE_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [STATE_W-1:0]  state,
    input  logic [CNT_W-1:0]    num_items,
    input  logic                ex_stop,
    output logic                param_rd_en,
    output logic [ADDR_W-1:0]   param_addr,
    output logic                data_rd_en,
    output logic [ADDR_W-1:0]   data_addr,
    output logic                wb_wr_en,
    output logic [ADDR_W-1:0]   wb_addr,
    output logic [CNT_W-1:0]    iter_cnt,
    output logic                finish
);

    logic [STATE_W-1:0]    state_q;
    logic [NUM_STATES-1:0] enter_oh_s;

    logic [CNT_W-1:0] limit_q,     limit_d;
    logic [CNT_W-1:0] iter_cnt_q,  iter_cnt_d;
    logic             stop_pend_q, stop_pend_d;
    logic             finish_q,    finish_d;

    logic             run_start_s;
    logic             wb_edge_s;
    logic [CNT_W:0]   iter_inc_s;
    logic             unused_entry_s;

    state_entry_decode u_state_entry_decode (
        .clk      (clk),
        .rst_n    (rst_n),
        .state    (state),
        .state_q  (state_q),
        .enter_oh (enter_oh_s)
    );

    // Entries that carry no action here are folded away explicitly.
    assign unused_entry_s = ^{enter_oh_s[IDLE], enter_oh_s[EX],
                              enter_oh_s[WRIT_PRE], enter_oh_s[DONE]};

    // Zero-latency strobes; once finish is up no further accesses are issued.
    assign param_rd_en = enter_oh_s[GET_PARAM]  & ~finish_q;
    assign data_rd_en  = enter_oh_s[GET_DATA]   & ~finish_q;
    assign wb_wr_en    = enter_oh_s[WRITE_BACK] & ~finish_q;

    // Addresses wrap modulo 2^ADDR_W by truncation.
    assign param_addr = PARAM_BASE + ADDR_W'(iter_cnt_q);
    assign data_addr  = DATA_BASE  + ADDR_W'(iter_cnt_q);
    assign wb_addr    = WB_BASE    + ADDR_W'(iter_cnt_q);

    assign iter_cnt = iter_cnt_q;
    assign finish   = finish_q;

    assign run_start_s = (state_q == IDLE) && (state == GET_PARAM);
    assign wb_edge_s   = wb_wr_en;
    // Widened increment so the limit compare cannot alias on overflow.
    assign iter_inc_s  = {1'b0, iter_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // Run bookkeeping: start-of-run load, early-stop capture, per-iteration count and finish.
    always_comb begin
        limit_d     = limit_q;
        iter_cnt_d  = iter_cnt_q;
        stop_pend_d = stop_pend_q;
        finish_d    = finish_q;
        if (state == IDLE) begin
            iter_cnt_d  = {CNT_W{1'b0}};
            stop_pend_d = 1'b0;
            finish_d    = 1'b0;
        end else if (run_start_s) begin
            limit_d     = num_items;
            iter_cnt_d  = {CNT_W{1'b0}};
            stop_pend_d = 1'b0;
            finish_d    = (num_items == {CNT_W{1'b0}});
        end else if (wb_edge_s) begin
            if (iter_cnt_q == {CNT_W{1'b1}}) begin
                iter_cnt_d = iter_cnt_q;
            end else begin
                iter_cnt_d = iter_inc_s[CNT_W-1:0];
            end
            finish_d = (iter_inc_s == {1'b0, limit_q}) || stop_pend_q;
        end else if ((state == EX) && ex_stop) begin
            stop_pend_d = 1'b1;
        end else begin
            stop_pend_d = stop_pend_q;
        end
    end

    // Run state registers; asynchronous reset abandons any partial iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit_q     <= {CNT_W{1'b0}};
            iter_cnt_q  <= {CNT_W{1'b0}};
            stop_pend_q <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            limit_q     <= limit_d;
            iter_cnt_q  <= iter_cnt_d;
            stop_pend_q <= stop_pend_d;
            finish_q    <= finish_d;
        end
    end

endmodule

// File: tb/tb_step_responder.sv
// Directed bench for step_responder: emulates the controller's state sequence
// and checks strobes, addresses, counter and finish against hand-derived values.
module tb_step_responder;
    import acc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  state;
    logic [15:0] num_items;
    logic        ex_stop;

    logic        param_rd_en, data_rd_en, wb_wr_en, finish;
    logic [15:0] param_addr, data_addr, wb_addr, iter_cnt;

    logic        p2_en, d2_en, w2_en, fin2;
    logic [15:0] p2_addr, d2_addr, w2_addr, it2;

    int tests = 0;
    int fails = 0;
    int n_p, n_d, n_w;

    always #5 clk = ~clk;

    step_responder dut (
        .clk(clk), .rst_n(rst_n), .state(state), .num_items(num_items), .ex_stop(ex_stop),
        .param_rd_en(param_rd_en), .param_addr(param_addr),
        .data_rd_en(data_rd_en), .data_addr(data_addr),
        .wb_wr_en(wb_wr_en), .wb_addr(wb_addr),
        .iter_cnt(iter_cnt), .finish(finish)
    );

    step_responder #(.WB_BASE(16'hFFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .state(state), .num_items(num_items), .ex_stop(ex_stop),
        .param_rd_en(p2_en), .param_addr(p2_addr),
        .data_rd_en(d2_en), .data_addr(d2_addr),
        .wb_wr_en(w2_en), .wb_addr(w2_addr),
        .iter_cnt(it2), .finish(fin2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a state for one cycle (driven at negedge) and tally strobes.
    task automatic go(input logic [2:0] s);
        @(negedge clk);
        state = s;
        #1;
        if (param_rd_en) n_p++;
        if (data_rd_en)  n_d++;
        if (wb_wr_en)    n_w++;
    endtask

    task automatic clr_counts();
        n_p = 0; n_d = 0; n_w = 0;
    endtask

    // One full controller iteration k; optionally raise ex_stop during EX.
    task automatic do_iter(input int k, input bit stop_here);
        logic [15:0] wrap_exp;
        wrap_exp = 16'hFFFF + k[15:0];
        go(GET_PARAM);
        chk("param_en",   {31'd0, param_rd_en}, 32'd1);
        chk("param_addr", {16'd0, param_addr},  32'(k));
        go(GET_DATA);
        chk("data_en",    {31'd0, data_rd_en},  32'd1);
        chk("data_addr",  {16'd0, data_addr},   32'h1000 + 32'(k));
        go(EX);
        ex_stop = stop_here;
        go(WRIT_PRE);
        ex_stop = 1'b0;
        chk("wp_no_wb",   {31'd0, wb_wr_en},    32'd0);
        go(WRITE_BACK);
        chk("wb_en",      {31'd0, wb_wr_en},    32'd1);
        chk("wb_addr",    {16'd0, wb_addr},     32'h2000 + 32'(k));
        chk("wb_wrap",    {16'd0, w2_addr},     {16'd0, wrap_exp});
        chk("wb_nofin",   {31'd0, finish},      32'd0);
    endtask

    initial begin
        rst_n = 1'b0; state = IDLE; num_items = 16'd0; ex_stop = 1'b0;
        clr_counts();
        #1;
        chk("rst_finish", {31'd0, finish},      32'd0);
        chk("rst_iter",   {16'd0, iter_cnt},    32'd0);
        chk("rst_paddr",  {16'd0, param_addr},  32'h0000);
        chk("rst_daddr",  {16'd0, data_addr},   32'h1000);
        chk("rst_waddr",  {16'd0, wb_addr},     32'h2000);
        chk("rst_strobe", {29'd0, param_rd_en, data_rd_en, wb_wr_en}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Three items, no stop.
        num_items = 16'd3;
        go(IDLE); clr_counts();
        do_iter(0, 1'b0); do_iter(1, 1'b0); do_iter(2, 1'b0);
        go(GET_PARAM);
        chk("n3_finish",  {31'd0, finish},      32'd1);
        chk("n3_pgate",   {31'd0, param_rd_en}, 32'd0);
        go(DONE);
        chk("n3_iter",    {16'd0, iter_cnt},    32'd3);
        chk("n3_cnt_p",   32'(n_p), 32'd3);
        chk("n3_cnt_d",   32'(n_d), 32'd3);
        chk("n3_cnt_w",   32'(n_w), 32'd3);

        // Zero items: one param read, then finish.
        go(IDLE); num_items = 16'd0; clr_counts();
        go(GET_PARAM);
        chk("n0_pen",     {31'd0, param_rd_en}, 32'd1);
        chk("n0_paddr",   {16'd0, param_addr},  32'h0000);
        chk("n0_nofin",   {31'd0, finish},      32'd0);
        go(GET_DATA);
        chk("n0_finish",  {31'd0, finish},      32'd1);
        chk("n0_dgate",   {31'd0, data_rd_en},  32'd0);
        go(DONE);
        chk("n0_iter",    {16'd0, iter_cnt},    32'd0);
        chk("n0_cnt_d",   32'(n_d), 32'd0);
        chk("n0_cnt_w",   32'(n_w), 32'd0);

        // Five items, stop requested in iteration 1.
        go(IDLE); num_items = 16'd5; clr_counts();
        do_iter(0, 1'b0); do_iter(1, 1'b1);
        go(GET_PARAM);
        chk("st_finish",  {31'd0, finish},      32'd1);
        chk("st_pgate",   {31'd0, param_rd_en}, 32'd0);
        go(DONE);
        chk("st_iter",    {16'd0, iter_cnt},    32'd2);
        chk("st_cnt_w",   32'(n_w), 32'd2);
        chk("st_cnt_p",   32'(n_p), 32'd2);

        // Asynchronous reset during EX of iteration 1 of 4.
        go(IDLE); num_items = 16'd4;
        do_iter(0, 1'b0);
        go(GET_PARAM); go(GET_DATA); go(EX);
        rst_n = 1'b0;
        #1;
        chk("ar_iter",    {16'd0, iter_cnt},    32'd0);
        chk("ar_finish",  {31'd0, finish},      32'd0);
        chk("ar_paddr",   {16'd0, param_addr},  32'h0000);
        chk("ar_daddr",   {16'd0, data_addr},   32'h1000);
        chk("ar_waddr",   {16'd0, wb_addr},     32'h2000);
        chk("ar_strobe",  {29'd0, param_rd_en, data_rd_en, wb_wr_en}, 32'd0);
        state = IDLE;
        @(negedge clk); rst_n = 1'b1;

        // Clean rerun with two items (also covers result-address wrap).
        num_items = 16'd2; go(IDLE); clr_counts();
        do_iter(0, 1'b0); do_iter(1, 1'b0);
        go(GET_PARAM);
        chk("rr_finish",  {31'd0, finish},      32'd1);
        go(DONE);
        chk("rr_iter",    {16'd0, iter_cnt},    32'd2);
        chk("rr_cnt_w",   32'(n_w), 32'd2);

        // Return to IDLE clears finish; next one-item run restarts at offset 0.
        go(IDLE);
        chk("id_hold",    {31'd0, finish},      32'd1);
        num_items = 16'd1;
        go(IDLE);
        chk("id_clear",   {31'd0, finish},      32'd0);
        chk("id_iter",    {16'd0, iter_cnt},    32'd0);
        clr_counts();
        do_iter(0, 1'b0);
        go(GET_PARAM);
        chk("r2_finish",  {31'd0, finish},      32'd1);
        go(DONE);
        chk("r2_iter",    {16'd0, iter_cnt},    32'd1);
        chk("r2_cnt_w",   32'(n_w), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
